branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 136 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution in ID: hazard-driven stall sequencing, redirect/flush pulse generation
// and resolved/taken branch statistics.
module branch_resolve_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             id_jal,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             mem_memread,
  input  logic             eq,
  output logic             stall,
  output logic             pc_redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_ifid,
  output logic [WIDTH-1:0] branch_cnt,
  output logic [WIDTH-1:0] taken_cnt
);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             redirect_q;
  logic [WIDTH-1:0] redirect_pc_q;
  logic [WIDTH-1:0] branch_cnt_q;
  logic [WIDTH-1:0] taken_cnt_q;

  logic             is_branch, is_jump;
  logic             ex_match, mem_match;
  logic [1:0]       need;
  logic             taken;
  logic             resolve;
  logic             stall_raw;
  logic [WIDTH-1:0] target;

  assign is_branch = id_valid & (id_beq | id_bne);
  assign is_jump   = id_valid & id_jal;

  // x0 is never a real dependency.
  assign ex_match  = (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign mem_match = (mem_rd != 5'd0) & ((mem_rd == id_rs1) | (mem_rd == id_rs2));

  always_comb begin
    need = 2'd0;
    if (ex_regwrite & ex_memread & ex_match) begin
      need = 2'd2;
    end else if (ex_regwrite & ex_match) begin
      need = 2'd1;
    end else if (mem_memread & mem_match) begin
      need = 2'd1;
    end
  end

  assign taken  = id_jal | (id_beq & eq) | (id_bne & ~eq);
  assign target = id_pc + id_imm;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    resolve   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_jump) begin
          resolve = 1'b1;
        end else if (is_branch) begin
          if (need != 2'd0) begin
            stall_raw = 1'b1;
            cnt_d     = need - 2'd1;
            state_d   = StStall;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      StStall: begin
        if (!id_valid) begin
          // Instruction vanished from ID: drop the pending branch.
          cnt_d   = 2'd0;
          state_d = StIdle;
        end else if (cnt_q != 2'd0) begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q - 2'd1;
        end else begin
          resolve = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 2'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= resolve & taken;
      if (resolve) begin
        redirect_pc_q <= target;
        branch_cnt_q  <= branch_cnt_q + 1'b1;
        if (taken) begin
          taken_cnt_q <= taken_cnt_q + 1'b1;
        end
      end
    end
  end

  assign stall       = rst_n & stall_raw;
  assign pc_redirect = redirect_q;
  assign flush_ifid  = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hazard stalls, resolution, x0 exemption,
// target wrap, reset and abort in the middle of a stall.
module tb_branch_resolve_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_beq, id_bne, id_jal;
  logic [WIDTH-1:0] id_pc, id_imm;
  logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
  logic             ex_regwrite, ex_memread, mem_memread, eq;
  logic             stall, pc_redirect, flush_ifid;
  logic [WIDTH-1:0] redirect_pc, branch_cnt, taken_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_beq     (id_beq),
    .id_bne     (id_bne),
    .id_jal     (id_jal),
    .id_pc      (id_pc),
    .id_imm     (id_imm),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .mem_rd     (mem_rd),
    .ex_regwrite(ex_regwrite),
    .ex_memread (ex_memread),
    .mem_memread(mem_memread),
    .eq         (eq),
    .stall      (stall),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .flush_ifid (flush_ifid),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered outputs after an edge.
  task automatic chk_regs(input string tag, input logic red, input logic [WIDTH-1:0] tgt,
                          input logic [WIDTH-1:0] bc, input logic [WIDTH-1:0] tc);
    chk({tag, ".pc_redirect"}, WIDTH'(pc_redirect), WIDTH'(red));
    chk({tag, ".flush_ifid"}, WIDTH'(flush_ifid), WIDTH'(red));
    chk({tag, ".redirect_pc"}, redirect_pc, tgt);
    chk({tag, ".branch_cnt"}, branch_cnt, bc);
    chk({tag, ".taken_cnt"}, taken_cnt, tc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_beq = 0; id_bne = 0; id_jal = 0;
    id_pc = '0; id_imm = '0; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; mem_rd = 0; ex_regwrite = 0; ex_memread = 0; mem_memread = 0; eq = 0;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    step();
    step();
    chk_regs("reset", 1'b0, 32'h0, 32'd0, 32'd0);
    // Stall is suppressed while reset is held even with a load-use hazard present.
    id_valid = 1; id_beq = 1; id_rs1 = 5'd3; ex_rd = 5'd3; ex_regwrite = 1; ex_memread = 1;
    #1;
    chk("reset.stall", WIDTH'(stall), 32'd0);

    // BEQ, no hazard, taken, resolves in the first cycle after reset.
    clear_inputs();
    rst_n = 1;
    id_valid = 1; id_beq = 1; id_pc = 32'h100; id_imm = 32'h20; id_rs1 = 1; id_rs2 = 2; eq = 1;
    #1;
    chk("beq.stall", WIDTH'(stall), 32'd0);
    step();
    chk_regs("beq", 1'b1, 32'h120, 32'd1, 32'd1);
    clear_inputs();
    step();
    chk_regs("idle_hold", 1'b0, 32'h120, 32'd1, 32'd1);

    // BNE load-use: two stall cycles, eq ignored until the resolve cycle.
    id_valid = 1; id_bne = 1; id_pc = 32'h200; id_imm = 32'h40; id_rs1 = 5; id_rs2 = 6;
    ex_rd = 5; ex_regwrite = 1; ex_memread = 1; eq = 1;
    #1;
    chk("bne.stall0", WIDTH'(stall), 32'd1);
    step();
    chk("bne.stall1", WIDTH'(stall), 32'd1);
    chk("bne.noredir1", WIDTH'(pc_redirect), 32'd0);
    step();
    eq = 0;
    #1;
    chk("bne.stall2", WIDTH'(stall), 32'd0);
    step();
    chk_regs("bne", 1'b1, 32'h240, 32'd2, 32'd2);
    clear_inputs();

    // BEQ with load in MEM: one stall, not taken.
    id_valid = 1; id_beq = 1; id_pc = 32'h300; id_imm = 32'h10; id_rs1 = 3; id_rs2 = 7;
    mem_rd = 7; mem_memread = 1; eq = 0;
    #1;
    chk("memld.stall0", WIDTH'(stall), 32'd1);
    step();
    chk("memld.stall1", WIDTH'(stall), 32'd0);
    step();
    chk_regs("memld", 1'b0, 32'h310, 32'd3, 32'd2);
    clear_inputs();

    // x0 dependency is exempt.
    id_valid = 1; id_beq = 1; id_pc = 32'h400; id_imm = 32'h8; id_rs1 = 0; id_rs2 = 4;
    ex_rd = 0; ex_regwrite = 1; eq = 1;
    #1;
    chk("x0.stall", WIDTH'(stall), 32'd0);
    step();
    chk_regs("x0", 1'b1, 32'h408, 32'd4, 32'd3);
    clear_inputs();

    // ALU result in EX: one stall, BNE with eq=1 not taken.
    id_valid = 1; id_bne = 1; id_pc = 32'h500; id_imm = 32'h4; id_rs1 = 9; id_rs2 = 1;
    ex_rd = 9; ex_regwrite = 1; eq = 1;
    #1;
    chk("alu.stall0", WIDTH'(stall), 32'd1);
    step();
    chk("alu.stall1", WIDTH'(stall), 32'd0);
    step();
    chk_regs("alu", 1'b0, 32'h504, 32'd5, 32'd3);
    clear_inputs();

    // JAL ignores hazards; target wraps.
    id_valid = 1; id_jal = 1; id_pc = 32'hFFFF_FFF0; id_imm = 32'h20; id_rs1 = 5;
    ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
    #1;
    chk("jal.stall", WIDTH'(stall), 32'd0);
    step();
    chk_regs("jal", 1'b1, 32'h10, 32'd6, 32'd4);
    clear_inputs();

    // Load-use BEQ, reset during the first stall cycle.
    id_valid = 1; id_beq = 1; id_pc = 32'h600; id_imm = 32'h4; id_rs1 = 8; id_rs2 = 2;
    ex_rd = 8; ex_regwrite = 1; ex_memread = 1; eq = 1;
    #1;
    chk("rststall.stall0", WIDTH'(stall), 32'd1);
    step();
    chk("rststall.stall1", WIDTH'(stall), 32'd1);
    rst_n = 0;
    #1;
    chk("rststall.stall_rst", WIDTH'(stall), 32'd0);
    step();
    chk_regs("rststall", 1'b0, 32'h0, 32'd0, 32'd0);
    rst_n = 1;
    #1;
    // Back in IDLE, the same hazard starts a fresh stall.
    chk("rststall.idle", WIDTH'(stall), 32'd1);
    step();
    chk("abort.stall1", WIDTH'(stall), 32'd1);
    id_valid = 0;
    #1;
    chk("abort.stall_inv", WIDTH'(stall), 32'd0);
    step();
    chk_regs("abort", 1'b0, 32'h0, 32'd0, 32'd0);

    // After abort the unit is in IDLE and resolves a clean BEQ immediately.
    clear_inputs();
    id_valid = 1; id_beq = 1; id_pc = 32'h700; id_imm = 32'hFFFF_FFFC; id_rs1 = 1; id_rs2 = 2;
    eq = 1;
    #1;
    chk("post_abort.stall", WIDTH'(stall), 32'd0);
    step();
    chk_regs("post_abort", 1'b1, 32'h6FC, 32'd1, 32'd1);
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
